// File: rtl/pulpemu_ctrl.sv
// pulpemu_ctrl: PS7 run-control for PULPino SoCs - reset sequencing, fetch enables,
// sticky end-of-computation capture and a saturating run-cycle counter.
module pulpemu_ctrl #(
  parameter int N_CORE   = 1,
  parameter int RST_HOLD = 16,
  parameter int CNT_W    = 32
) (
  input  logic              ps7_clk,
  input  logic              ps7_rst_n,
  input  logic [31:0]       ctrl_i,
  input  logic [N_CORE-1:0] eoc_i,
  output logic              rstn_soc_o,
  output logic [N_CORE-1:0] fetch_en_o,
  output logic [31:0]       status_o,
  output logic [CNT_W-1:0]  cycle_cnt_o
);
  localparam int HW = $clog2(RST_HOLD + 1);
  typedef enum logic [1:0] {HOLD = 2'd0, IDLE = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;
  state_t state, next_state;
  logic [31:0] ctrl_q;
  logic [N_CORE-1:0] eoc_m, eoc_s, eoc_set, eoc_sticky, fetch_req;
  logic [HW-1:0] hold_cnt;
  logic run_req, start, all_done, cnt_clr, cnt_sat;
  logic unused_ctrl;
  assign fetch_req   = ctrl_q[N_CORE-1:0];
  assign run_req     = ctrl_q[31];
  assign eoc_set     = eoc_s & fetch_en_o;
  assign all_done    = (fetch_en_o != '0) && (((eoc_sticky | eoc_set) & fetch_en_o) == fetch_en_o);
  assign start       = (state == IDLE) && (next_state == RUN);
  assign cnt_clr     = ctrl_q[30] || start;
  assign cnt_sat     = &cycle_cnt_o;
  assign unused_ctrl = ^ctrl_q[29:N_CORE];
  assign status_o    = {21'd0, cnt_sat, state, 8'(eoc_sticky)};
  // a dropped run request overrides every other transition
  always_comb begin
    next_state = state;
    if (!run_req) next_state = HOLD;
    else
      case (state)
        HOLD:    next_state = (hold_cnt == '0) ? IDLE : HOLD;
        IDLE:    next_state = (fetch_req != '0) ? RUN : IDLE;
        RUN:     next_state = (fetch_req == '0) ? IDLE : all_done ? DONE : RUN;
        DONE:    next_state = (fetch_req == '0) ? IDLE : DONE;
        default: next_state = HOLD;
      endcase
  end
  always_ff @(posedge ps7_clk or negedge ps7_rst_n)
    if (!ps7_rst_n) begin
      ctrl_q      <= '0;
      eoc_m       <= '0;
      eoc_s       <= '0;
      state       <= HOLD;
      hold_cnt    <= HW'(RST_HOLD);
      rstn_soc_o  <= 1'b0;
      fetch_en_o  <= '0;
      eoc_sticky  <= '0;
      cycle_cnt_o <= '0;
    end else begin
      ctrl_q      <= ctrl_i;
      eoc_m       <= eoc_i;
      eoc_s       <= eoc_m;
      state       <= next_state;
      hold_cnt    <= !run_req ? HW'(RST_HOLD) : (state == HOLD && hold_cnt != '0) ? hold_cnt - HW'(1) : hold_cnt;
      rstn_soc_o  <= next_state != HOLD;
      fetch_en_o  <= (next_state == HOLD) ? '0 : fetch_req;
      eoc_sticky  <= (next_state == HOLD || start) ? '0 : eoc_sticky | eoc_set;
      cycle_cnt_o <= cnt_clr ? '0 : (state == RUN && !cnt_sat) ? cycle_cnt_o + CNT_W'(1) : cycle_cnt_o;
    end
endmodule

// File: tb/tb_pulpemu_ctrl.sv
// tb_pulpemu_ctrl: directed vector table plus randomized run against a cycle-level reference model.
module tb_pulpemu_ctrl;
  logic ps7_clk = 1'b0;
  logic ps7_rst_n = 1'b0;
  logic [31:0] ctrl_i = 32'h8000_0000;
  logic [1:0] eoc_i = 2'b00;
  logic rstn_soc_o;
  logic [1:0] fetch_en_o;
  logic [31:0] status_o;
  logic [7:0] cycle_cnt_o;
  int vectors = 0;
  int miscompares = 0;
  always #5 ps7_clk = ~ps7_clk;
  pulpemu_ctrl #(.N_CORE(2), .RST_HOLD(4), .CNT_W(8)) dut (
    .ps7_clk(ps7_clk), .ps7_rst_n(ps7_rst_n), .ctrl_i(ctrl_i), .eoc_i(eoc_i),
    .rstn_soc_o(rstn_soc_o), .fetch_en_o(fetch_en_o), .status_o(status_o), .cycle_cnt_o(cycle_cnt_o)
  );
  typedef struct {
    logic [31:0] ctrl;
    logic [1:0]  eoc;
    int          n;
    logic        rstn;
    logic [1:0]  fe;
    logic [31:0] st;
    logic [7:0]  cnt;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(logic [31:0] c, logic [1:0] e, int n, logic r, logic [1:0] f, logic [31:0] s, logic [7:0] k);
    vec_t v;
    v.ctrl = c; v.eoc = e; v.n = n; v.rstn = r; v.fe = f; v.st = s; v.cnt = k;
    return v;
  endfunction
  // reference model: state as plain ints (0 HOLD, 1 IDLE, 2 RUN, 3 DONE), synchroniser as a queue
  bit [31:0] m_cq;
  bit [1:0] m_pipe[$];
  int m_st, m_hold, m_cnt;
  bit m_rstn;
  bit [1:0] m_fe, m_stk;
  task automatic m_reset();
    m_cq = '0; m_pipe = '{2'b00, 2'b00}; m_st = 0; m_hold = 4;
    m_rstn = 0; m_fe = '0; m_stk = '0; m_cnt = 0;
  endtask
  task automatic m_step(input bit [31:0] ci, input bit [1:0] ei);
    bit run, done, entry;
    bit [1:0] en, set;
    int nst;
    run = m_cq[31];
    en = m_cq[1:0];
    set = m_pipe[0] & m_fe;
    done = m_fe != 0;
    for (int i = 0; i < 2; i++) if (m_fe[i] && !m_stk[i] && !set[i]) done = 0;
    if (!run) nst = 0;
    else if (m_st == 0) nst = (m_hold == 0) ? 1 : 0;
    else if (m_st == 1) nst = (en != 0) ? 2 : 1;
    else if (m_st == 2) nst = (en == 0) ? 1 : done ? 3 : 2;
    else nst = (en == 0) ? 1 : 3;
    entry = (m_st == 1) && (nst == 2);
    if (m_cq[30] || entry) m_cnt = 0;
    else if (m_st == 2 && m_cnt < 255) m_cnt++;
    m_stk = (nst == 0 || entry) ? 2'b00 : (m_stk | set);
    if (!run) m_hold = 4;
    else if (m_st == 0 && m_hold > 0) m_hold--;
    m_rstn = nst != 0;
    m_fe = (nst == 0) ? 2'b00 : en;
    m_st = nst;
    void'(m_pipe.pop_front());
    m_pipe.push_back(ei);
    m_cq = ci;
  endtask
  function automatic logic [31:0] m_status();
    return 32'(m_stk) | (32'(m_st) << 8) | ((m_cnt == 255) ? 32'h400 : 32'h0);
  endfunction
  task automatic check(string tag, logic r, logic [1:0] f, logic [31:0] s, logic [7:0] c);
    vectors++;
    if (rstn_soc_o !== r || fetch_en_o !== f || status_o !== s || cycle_cnt_o !== c) begin
      miscompares++;
      $display("FAIL %s: got rstn=%0b fetch=%b status=%h cnt=%0d, want rstn=%0b fetch=%b status=%h cnt=%0d",
               tag, rstn_soc_o, fetch_en_o, status_o, cycle_cnt_o, r, f, s, c);
    end
  endtask
  task automatic tick(string tag);
    @(posedge ps7_clk);
    m_step(ctrl_i, eoc_i);
    #1;
    check(tag, m_rstn, m_fe, m_status(), 8'(m_cnt));
  endtask
  task automatic do_reset();
    #2 ps7_rst_n = 1'b0;
    m_reset();
    #1 check("async_rst", 1'b0, 2'b00, 32'h0, 8'h0);
    @(negedge ps7_clk);
    ps7_rst_n = 1'b1;
  endtask
  initial begin
    logic [31:0] c;
    tbl.push_back(mk(32'h8000_0000, 2'b00,   5, 0, 2'b00, 32'h000, 0));
    tbl.push_back(mk(32'h8000_0000, 2'b00,   1, 1, 2'b00, 32'h100, 0));
    tbl.push_back(mk(32'h8000_0003, 2'b00,   1, 1, 2'b00, 32'h100, 0));
    tbl.push_back(mk(32'h8000_0003, 2'b00,   1, 1, 2'b11, 32'h200, 0));
    tbl.push_back(mk(32'h8000_0003, 2'b00,   8, 1, 2'b11, 32'h200, 8));
    tbl.push_back(mk(32'h8000_0003, 2'b01,   2, 1, 2'b11, 32'h200, 10));
    tbl.push_back(mk(32'h8000_0003, 2'b01,   1, 1, 2'b11, 32'h201, 11));
    tbl.push_back(mk(32'h8000_0003, 2'b01,   9, 1, 2'b11, 32'h201, 20));
    tbl.push_back(mk(32'h8000_0003, 2'b11,   2, 1, 2'b11, 32'h201, 22));
    tbl.push_back(mk(32'h8000_0003, 2'b11,   1, 1, 2'b11, 32'h303, 23));
    tbl.push_back(mk(32'h8000_0003, 2'b11,   5, 1, 2'b11, 32'h303, 23));
    tbl.push_back(mk(32'h8000_0000, 2'b00,   2, 1, 2'b00, 32'h103, 23));
    tbl.push_back(mk(32'h8000_0001, 2'b00,   2, 1, 2'b01, 32'h200, 0));
    tbl.push_back(mk(32'h8000_0001, 2'b00,   5, 1, 2'b01, 32'h200, 5));
    tbl.push_back(mk(32'h8000_0000, 2'b00,   1, 1, 2'b01, 32'h200, 6));
    tbl.push_back(mk(32'h8000_0000, 2'b00,   1, 1, 2'b00, 32'h100, 7));
    tbl.push_back(mk(32'hC000_0000, 2'b00,   1, 1, 2'b00, 32'h100, 7));
    tbl.push_back(mk(32'h8000_0000, 2'b00,   1, 1, 2'b00, 32'h100, 0));
    tbl.push_back(mk(32'h8000_0000, 2'b00,   1, 1, 2'b00, 32'h100, 0));
    tbl.push_back(mk(32'h8000_0001, 2'b10,   2, 1, 2'b01, 32'h200, 0));
    tbl.push_back(mk(32'h8000_0001, 2'b10,   5, 1, 2'b01, 32'h200, 5));
    tbl.push_back(mk(32'h8000_0001, 2'b11,   3, 1, 2'b01, 32'h301, 8));
    tbl.push_back(mk(32'h8000_0000, 2'b00,   2, 1, 2'b00, 32'h101, 8));
    tbl.push_back(mk(32'h8000_0003, 2'b00,   2, 1, 2'b11, 32'h200, 0));
    tbl.push_back(mk(32'h8000_0003, 2'b01,   3, 1, 2'b11, 32'h201, 3));
    tbl.push_back(mk(32'h0000_0003, 2'b01,   1, 1, 2'b11, 32'h201, 4));
    tbl.push_back(mk(32'h8000_0003, 2'b01,   1, 0, 2'b00, 32'h000, 5));
    tbl.push_back(mk(32'h8000_0003, 2'b01,   4, 0, 2'b00, 32'h000, 5));
    tbl.push_back(mk(32'h8000_0003, 2'b01,   1, 1, 2'b11, 32'h100, 5));
    tbl.push_back(mk(32'h8000_0003, 2'b01,   1, 1, 2'b11, 32'h200, 0));
    tbl.push_back(mk(32'h8000_0003, 2'b01,   1, 1, 2'b11, 32'h201, 1));
    tbl.push_back(mk(32'h8000_0003, 2'b00, 300, 1, 2'b11, 32'h601, 255));
    tbl.push_back(mk(32'hC000_0003, 2'b00,   2, 1, 2'b11, 32'h201, 0));
    tbl.push_back(mk(32'h8000_0003, 2'b00,   2, 1, 2'b11, 32'h201, 1));
    m_reset();
    #3 check("reset", 1'b0, 2'b00, 32'h0, 8'h0);
    @(negedge ps7_clk);
    ps7_rst_n = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      ctrl_i = tbl[i].ctrl;
      eoc_i = tbl[i].eoc;
      repeat (tbl[i].n) tick($sformatf("row%0d_step", i));
      check($sformatf("row%0d", i), tbl[i].rstn, tbl[i].fe, tbl[i].st, tbl[i].cnt);
    end
    do_reset();
    for (int s = 0; s < 250; s++) begin
      c = $urandom;
      c[31] = $urandom_range(0, 7) != 0;
      c[30] = $urandom_range(0, 15) == 0;
      ctrl_i = c;
      eoc_i = 2'($urandom);
      repeat ($urandom_range(1, 8)) tick("rand");
      if ($urandom_range(0, 39) == 0) do_reset();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
